// File: rtl/sram_access_ctrl.sv
// Sequences 32-bit MEM-stage reads and writes onto a 16-bit SRAM as two half-word phases (LO then HI).
// The SRAM address and data outputs are decoded from the current state and follow addr/wdata directly.
module sram_access_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_en,
    input  logic        MEM_W_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic [31:0] eff;
    logic        in_phase;
    logic        unused_eff_bits;

    assign req             = MEM_R_en | MEM_W_en;
    assign eff             = addr - 32'(BASE_ADDR);
    assign unused_eff_bits = ^{eff[31:19], eff[1:0]};
    assign in_phase        = (state_q == LO) || (state_q == HI);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                    op_wr_d = MEM_W_en;
                end
            end
            LO: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = HI;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[15:0] = SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[31:16] = SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded from state so an async reset drops write strobes without waiting for a clock edge.
    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        case (state_q)
            IDLE:    ready = ~req;
            DONE:    ready = 1'b1;
            LO: begin
                SRAM_ADDR = {eff[18:2], 1'b0};
                if (op_wr_q) SRAM_DQ_out = wdata[15:0];
            end
            HI: begin
                SRAM_ADDR = {eff[18:2], 1'b1};
                if (op_wr_q) SRAM_DQ_out = wdata[31:16];
            end
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ_oe = in_phase & op_wr_q;
    assign SRAM_WE_N  = ~(in_phase & op_wr_q);
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: cycle-indexed access model, bench-side SRAM array, directed and random requests.
module tb_sram_access_ctrl;

    localparam int unsigned BASE = 1024;
    localparam int          W    = 1;
    localparam int          L    = W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_en = 1'b0, MEM_W_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N;

    logic [15:0] sram_mem [0:1023];
    logic [15:0] noise = '0;
    bit          noise_en = 1'b0;

    // Second instance with zero wait cycles, driven by its own request lines.
    logic        r0 = 1'b0, w0 = 1'b0, r0_nx = 1'b0, w0_nx = 1'b0;
    logic [31:0] rdata0;
    logic        ready0, oe0, we0_n;
    logic [17:0] addr0_o;
    logic [15:0] dq0_o;
    logic [15:0] dq0_in = 16'h5A5A;

    int total = 0;
    int bad   = 0;

    logic [17:0] cap_addr [4];
    logic [15:0] cap_dq   [4];
    logic [1:0]  cap_ctl  [4];

    always #5 clk = ~clk;

    assign SRAM_DQ_in = sram_mem[SRAM_ADDR[9:0]] ^ noise;

    sram_access_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N)
    );

    sram_access_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .MEM_R_en(r0), .MEM_W_en(w0),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
        .SRAM_ADDR(addr0_o), .SRAM_DQ_out(dq0_o), .SRAM_DQ_oe(oe0),
        .SRAM_DQ_in(dq0_in), .SRAM_WE_N(we0_n)
    );

    function automatic logic [17:0] exp_half(input logic [31:0] a, input bit hi);
        logic [31:0] words;
        words = (a - BASE) >> 2;
        return 18'((words << 1) + 32'(hi));
    endfunction

    function automatic logic [15:0] exp_rd(input logic [31:0] a, input bit hi);
        logic [17:0] h;
        h = exp_half(a, hi);
        return sram_mem[h[9:0]] ^ noise;
    endfunction

    // Model: pos = cycles since the access left IDLE; 0..L-1 low half, L..2L-1 high half, 2L done.
    int          pos = -1;
    bit          m_wr = 1'b0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos     <= -1;
            m_wr    <= 1'b0;
            m_rdata <= '0;
        end else if (pos < 0) begin
            if (MEM_R_en | MEM_W_en) begin
                pos  <= 0;
                m_wr <= MEM_W_en;
            end
        end else if (pos == 2 * L) begin
            pos <= -1;
        end else begin
            if (!m_wr && pos == L - 1)     m_rdata[15:0]  <= exp_rd(addr, 1'b0);
            if (!m_wr && pos == 2 * L - 1) m_rdata[31:16] <= exp_rd(addr, 1'b1);
            pos <= pos + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit   idle, lo, hi, done;
        logic exp_rdy;
        logic [31:0] exp_addr, exp_dq;
        idle     = (pos < 0);
        lo       = (pos >= 0) && (pos < L);
        hi       = (pos >= L) && (pos < 2 * L);
        done     = (pos == 2 * L);
        exp_rdy  = idle ? !(MEM_R_en | MEM_W_en) : done;
        exp_addr = lo ? 32'(exp_half(addr, 1'b0)) : hi ? 32'(exp_half(addr, 1'b1)) : 32'd0;
        exp_dq   = (lo && m_wr) ? {16'd0, wdata[15:0]} : (hi && m_wr) ? {16'd0, wdata[31:16]} : 32'd0;
        chk("ready", 32'(ready), 32'(exp_rdy));
        chk("sram_addr", 32'(SRAM_ADDR), exp_addr);
        chk("we_n", 32'(SRAM_WE_N), 32'(!((lo || hi) && m_wr)));
        chk("oe", 32'(SRAM_DQ_oe), 32'((lo || hi) && m_wr));
        if (!(lo || hi) || m_wr) chk("dq_out", 32'(SRAM_DQ_out), exp_dq);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic drive_cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MEM_R_en = r;
        MEM_W_en = w;
        addr     = a;
        wdata    = d;
        r0       = r0_nx;
        w0       = w0_nx;
        noise    = noise_en ? 16'($urandom) : 16'd0;
        #1;
        check_all();
        if (!SRAM_WE_N) sram_mem[SRAM_ADDR[9:0]] = SRAM_DQ_out;
    endtask

    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output int low);
        bit fin;
        fin = 1'b0;
        low = 0;
        for (int i = 0; i < 20 && !fin; i++) begin
            drive_cycle(r, w, a, d);
            if (ready) begin
                fin = 1'b1;
            end else begin
                if (low >= 1 && low <= 4) begin
                    cap_addr[low-1] = SRAM_ADDR;
                    cap_dq[low-1]   = SRAM_DQ_out;
                    cap_ctl[low-1]  = {SRAM_DQ_oe, SRAM_WE_N};
                end
                low++;
            end
        end
    endtask

    initial begin
        int          low;
        int          we0_low;
        logic [8:0]  pat;
        bit          act;
        logic        rr, ww;
        logic [31:0] ra, rd;

        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'($urandom);
        sram_mem[4] = 16'h1234;
        sram_mem[5] = 16'hABCD;

        repeat (2) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
        rst = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);

        run_access(1'b1, 1'b0, BASE + 8, 32'd0, low);
        chk("rd_ready_low", 32'(low), 32'd5);
        chk("rd_data", rdata, 32'hABCD1234);
        drive_cycle(1'b0, 1'b0, BASE + 8, 32'd0);

        run_access(1'b0, 1'b1, BASE + 12, 32'hDEADBEEF, low);
        chk("wr_ready_low", 32'(low), 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk("wr_addr", 32'(cap_addr[k]), (k < 2) ? 32'd6 : 32'd7);
            chk("wr_dq", 32'(cap_dq[k]), (k < 2) ? 32'h0000BEEF : 32'h0000DEAD);
            chk("wr_oe_we", 32'(cap_ctl[k]), 32'b10);
        end
        chk("wr_rdata_kept", rdata, 32'hABCD1234);
        chk("wr_mem_lo", 32'(sram_mem[6]), 32'h0000BEEF);
        chk("wr_mem_hi", 32'(sram_mem[7]), 32'h0000DEAD);
        drive_cycle(1'b0, 1'b0, BASE + 12, 32'd0);

        run_access(1'b1, 1'b1, BASE + 16, 32'h11223344, low);
        chk("both_ready_low", 32'(low), 32'd5);
        chk("both_rdata_kept", rdata, 32'hABCD1234);
        chk("both_mem_lo", 32'(sram_mem[8]), 32'h00003344);
        chk("both_mem_hi", 32'(sram_mem[9]), 32'h00001122);
        drive_cycle(1'b0, 1'b0, BASE + 16, 32'd0);

        // Reset landing in the high half of a write, between clock edges.
        repeat (4) drive_cycle(1'b0, 1'b1, BASE + 40, 32'hCAFEF00D);
        chk("hi_we_n_before_rst", 32'(SRAM_WE_N), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        check_all();
        drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_we_n", 32'(SRAM_WE_N), 32'd1);

        // Zero-wait instance: read immediately followed by write.
        pat     = 9'b110001000;
        we0_low = 0;
        for (int i = 0; i < 9; i++) begin
            r0_nx = (i < 4);
            w0_nx = (i >= 4 && i < 8);
            drive_cycle(1'b0, 1'b0, BASE + 20, 32'h89ABCDEF);
            chk("wait0_ready", 32'(ready0), 32'(pat[i]));
            if (!we0_n) we0_low++;
            if (i == 3) chk("wait0_rdata", rdata0, 32'h5A5A5A5A);
        end
        chk("wait0_we_cycles", 32'(we0_low), 32'd2);
        chk("wait0_rdata_kept", rdata0, 32'h5A5A5A5A);
        chk("wait0_idle_addr", 32'(addr0_o), 32'd0);
        chk("wait0_idle_dq", 32'(dq0_o), 32'd0);
        chk("wait0_idle_oe", 32'(oe0), 32'd0);

        noise_en = 1'b1;
        act = 1'b0;
        rr  = 1'b0;
        ww  = 1'b0;
        ra  = BASE;
        rd  = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!act && $urandom_range(0, 2) != 0) begin
                act = 1'b1;
                case ($urandom_range(0, 2))
                    0:       {rr, ww} = 2'b10;
                    1:       {rr, ww} = 2'b01;
                    default: {rr, ww} = 2'b11;
                endcase
                ra = $urandom_range(BASE - 32, BASE + 4095);
                rd = $urandom;
            end else if (act && $urandom_range(0, 15) == 0) begin
                ra = $urandom_range(BASE - 32, BASE + 4095);
                rd = $urandom;
                if ($urandom_range(0, 1) == 1) {rr, ww} = {ww, rr};
            end
            drive_cycle(act & rr, act & ww, ra, rd);
            if (act && ready) act = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 1024: byte offset subtracted from addr before mapping to SRAM.
REQ-002 Parameter WAIT_CYCLES, default 1: extra SRAM cycles per half-word phase; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 MEM_R_en  input  1  word read request from MEM stage, held until ready.
REQ-006 MEM_W_en  input  1  word write request from MEM stage, held until ready.
REQ-007 addr  input  32  byte address of request.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  registered read data.
REQ-010 ready  output  1  combinational; low means freeze the pipeline.
REQ-011 SRAM_ADDR  output  18  half-word address to 16-bit SRAM.
REQ-012 SRAM_DQ_out  output  16  write data to SRAM.
REQ-013 SRAM_DQ_oe  output  1  1 = controller drives SRAM data bus.
REQ-014 SRAM_DQ_in  input  16  read data from SRAM.
REQ-015 SRAM_WE_N  output  1  active-low SRAM write enable.

Function
REQ-016 FSM states are IDLE, LO, HI and DONE; a wait counter of 4 bits runs in LO and HI.
REQ-017 Request: req = MEM_R_en | MEM_W_en; when both are high, the access is a write.
REQ-018 IDLE: ready = ~req; on an edge with req=1, latch the op type, go to LO, counter=0.
REQ-019 LO/HI: each lasts exactly WAIT_CYCLES+1 cycles; the counter increments each cycle, and the phase ends on the edge where counter==WAIT_CYCLES.
REQ-020 LO ends -> HI with counter=0; HI ends -> DONE.
REQ-021 DONE: ready=1 for exactly one cycle, then unconditional transition to IDLE.
REQ-022 ready=0 in LO and HI regardless of req.
REQ-023 Mapping: eff = addr - BASE_ADDR (32-bit, wrap ignored); SRAM_ADDR = {eff[18:2], 0} in LO and {eff[18:2], 1} in HI; addr[1:0] ignored.
REQ-024 Read, LO end edge: rdata[15:0] <= SRAM_DQ_in; HI end edge: rdata[31:16] <= SRAM_DQ_in.
REQ-025 rdata holds its value until the next read overwrites it; writes never change rdata.
REQ-026 Write: in LO, SRAM_DQ_out = wdata[15:0]; in HI, SRAM_DQ_out = wdata[31:16]; SRAM_DQ_oe=1 and SRAM_WE_N=0 for every cycle of both phases.
REQ-027 Read phases, IDLE and DONE: SRAM_DQ_oe=0 and SRAM_WE_N=1.
REQ-028 Outside LO/HI: SRAM_ADDR=0 and SRAM_DQ_out=0.
REQ-029 Total ready-low cycles per access = 1 + 2*(WAIT_CYCLES+1); with default 5 cycles, ready=1 in the 6th.
REQ-030 addr/wdata/request changes during LO/HI are sampled live (requester holds them); op type stays as latched in IDLE.
REQ-031 Back-to-back: after DONE, a request in IDLE starts a new access with no extra bubble beyond REQ-018.

Reset
REQ-032 rst=0 at any time, including mid-access, immediately forces: state=IDLE, counter=0, rdata=0, SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
REQ-033 After reset release, ready = ~req, and no SRAM write occurs until a new request is seen in IDLE.

Verification
REQ-034 Read, WAIT=1, addr=1024+8, SRAM returns 0x1234 at half-addr 4 and 0xABCD at half-addr 5 -> ready low 5 cycles, rdata=0xABCD1234 in DONE cycle.
REQ-035 Write, addr=1024+12, wdata=0xDEADBEEF -> SRAM_ADDR=6 with DQ_out=0xBEEF for 2 cycles, then 7 with 0xDEAD for 2 cycles, WE_N=0 and oe=1 for all 4, ready in the 6th cycle; rdata unchanged.
REQ-036 MEM_R_en=MEM_W_en=1 -> write performed per REQ-035 and rdata unchanged.
REQ-037 rst asserted in HI of a write -> WE_N=1 and oe=0 with no clock edge needed; state=IDLE; after release with no req, ready=1.
REQ-038 WAIT_CYCLES=0 read followed immediately by a write -> ready low 3 cycles, high 1 cycle, then low 3 cycles, high 1 cycle.
REQ-039 No request -> ready=1 constantly, WE_N=1, oe=0.
